// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_STARVE_LIMIT = 4;

    // Which requester owns the read data returning from the RAM this cycle.
    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_owner_e;

    // Control half of a RAM access.
    typedef struct packed {
        logic       en;
        logic       we;
        logic [3:0] be;
    } mem_ctrl_t;

    localparam mem_ctrl_t MEM_CTRL_IDLE = '0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and RAM-side signals of the memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32
);
    // fetch port
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic          o_if_gnt;
    logic          o_if_rvalid;
    logic [31:0]   o_if_rdata;
    // data port
    logic          i_d_req;
    logic          i_d_we;
    logic [3:0]    i_d_be;
    logic [AW-1:0] i_d_addr;
    logic [31:0]   i_d_wdata;
    logic          o_d_gnt;
    logic          o_d_rvalid;
    logic [31:0]   o_d_rdata;
    // single-port synchronous RAM
    logic          o_mem_en;
    logic          o_mem_we;
    logic [3:0]    o_mem_be;
    logic [AW-3:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [31:0]   i_mem_rdata;

    // Arbiter side.
    modport slave (
        input  i_if_req, i_if_addr,
        input  i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
        input  i_mem_rdata,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        output o_d_gnt, o_d_rvalid, o_d_rdata,
        output o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata
    );

    // Requesters plus RAM side.
    modport master (
        output i_if_req, i_if_addr,
        output i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
        output i_mem_rdata,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        input  o_d_gnt, o_d_rvalid, o_d_rdata,
        input  o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one synchronous single-port RAM.
// Data has priority; a saturating starve counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants while fetch is waiting.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned AW           = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned    CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;
    rsp_owner_e    rsp_q, rsp_d;

    logic          starve_hit;
    logic          if_gnt;
    logic          d_gnt;
    mem_ctrl_t     mem_ctrl;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          if_rvalid, d_rvalid;
    logic [31:0]   if_rdata, d_rdata;

    // Byte offset bits are irrelevant to a word-wide RAM.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.i_if_addr[1:0], bus.i_d_addr[1:0]};

    // Grant decision: data first unless fetch has been starved long enough.
    always_comb begin
        starve_hit = (starve_q == LIMIT);
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if (i_reset_n) begin
            if (bus.i_if_req && (starve_hit || !bus.i_d_req)) begin
                if_gnt = 1'b1;
            end else if (bus.i_d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Route the granted requester onto the RAM port.
    always_comb begin
        mem_ctrl  = MEM_CTRL_IDLE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_ctrl = '{en: 1'b1, we: 1'b0, be: 4'hF};
            mem_addr = bus.i_if_addr[AW-1:2];
        end else if (d_gnt) begin
            mem_ctrl  = '{en: 1'b1, we: bus.i_d_we, be: bus.i_d_be};
            mem_addr  = bus.i_d_addr[AW-1:2];
            mem_wdata = bus.i_d_wdata;
        end
    end

    // Starve counter next state: counts data wins over a waiting fetch.
    always_comb begin
        starve_d = starve_q;
        if (if_gnt || !bus.i_if_req) begin
            starve_d = '0;
        end else if (d_gnt && !starve_hit) begin
            starve_d = starve_q + CW'(1);
        end
    end

    // Response owner next state and read-data steering.
    always_comb begin
        rsp_d     = RSP_NONE;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        if (if_gnt) begin
            rsp_d = RSP_IF;
        end else if (d_gnt) begin
            rsp_d = RSP_D;
        end
        case (rsp_q)
            RSP_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = bus.i_mem_rdata;
            end
            RSP_D: begin
                d_rvalid = 1'b1;
                d_rdata  = bus.i_mem_rdata;
            end
            default: ;
        endcase
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            starve_q <= '0;
            rsp_q    <= RSP_NONE;
        end else begin
            starve_q <= starve_d;
            rsp_q    <= rsp_d;
        end
    end

    assign bus.o_if_gnt    = if_gnt;
    assign bus.o_d_gnt     = d_gnt;
    assign bus.o_mem_en    = mem_ctrl.en;
    assign bus.o_mem_we    = mem_ctrl.we;
    assign bus.o_mem_be    = mem_ctrl.be;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_wdata = mem_wdata;
    assign bus.o_if_rvalid = if_rvalid;
    assign bus.o_if_rdata  = if_rdata;
    assign bus.o_d_rvalid  = d_rvalid;
    assign bus.o_d_rdata   = d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural synchronous RAM.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic fill  = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32)) bus();

    mem_port_arbiter #(
        .STARVE_LIMIT(4),
        .AW(32)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    function automatic logic [31:0] pat(input int unsigned i);
        return {8'hA5, 8'(i), ~8'(i), 8'(i * 3)};
    endfunction

    // Behavioural RAM: read-before-write, data one cycle after enable.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(i);
        end else if (bus.o_mem_en) begin
            bus.i_mem_rdata <= ram[bus.o_mem_addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (bus.o_mem_we && bus.o_mem_be[b])
                    ram[bus.o_mem_addr[7:0]][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
        end
    end

    typedef struct {
        rsp_owner_e  own;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] shadow [256];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare this cycle's response against what the previous cycle's grant promised.
    task automatic check_rsp(input string tag);
        exp_t        e;
        logic [32:0] ei = '0;
        logic [32:0] ed = '0;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.own == RSP_IF) ei = {1'b1, e.data};
            else                 ed = {1'b1, e.data};
        end
        check({tag, "/if_rsp"}, 64'({bus.o_if_rvalid, bus.o_if_rdata}), 64'(ei));
        check({tag, "/d_rsp"},  64'({bus.o_d_rvalid,  bus.o_d_rdata}),  64'(ed));
    endtask

    // Drive one cycle of requests, check grant and RAM port, queue the response.
    task automatic step(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dwe, input logic [3:0] dbe,
                        input logic [31:0] da, input logic [31:0] dwd,
                        input rsp_owner_e eg, input string tag);
        int unsigned w;
        logic [1:0]  eg_bits;
        bus.i_if_req   = ir;
        bus.i_if_addr  = ia;
        bus.i_d_req    = dr;
        bus.i_d_we     = dwe;
        bus.i_d_be     = dbe;
        bus.i_d_addr   = da;
        bus.i_d_wdata  = dwd;
        @(negedge clk);
        check_rsp(tag);
        eg_bits = (eg == RSP_IF) ? 2'b10 : (eg == RSP_D) ? 2'b01 : 2'b00;
        check({tag, "/gnt"}, 64'({bus.o_if_gnt, bus.o_d_gnt}), 64'(eg_bits));
        case (eg)
            RSP_IF: begin
                w = int'(ia[9:2]);
                check({tag, "/mem"},
                      64'({bus.o_mem_en, bus.o_mem_we, bus.o_mem_be, bus.o_mem_addr}),
                      64'({1'b1, 1'b0, 4'hF, ia[31:2]}));
                sbq.push_back('{RSP_IF, shadow[w]});
            end
            RSP_D: begin
                w = int'(da[9:2]);
                check({tag, "/mem"},
                      64'({bus.o_mem_en, bus.o_mem_we, bus.o_mem_be, bus.o_mem_addr}),
                      64'({1'b1, dwe, dbe, da[31:2]}));
                if (dwe) check({tag, "/wdata"}, 64'(bus.o_mem_wdata), 64'(dwd));
                sbq.push_back('{RSP_D, shadow[w]});
                if (dwe)
                    for (int b = 0; b < 4; b++)
                        if (dbe[b]) shadow[w][8*b +: 8] = dwd[8*b +: 8];
            end
            default: begin
                check({tag, "/mem_idle"},
                      64'({bus.o_mem_en, bus.o_mem_we, bus.o_mem_be}), 64'(6'b0));
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, RSP_NONE, tag);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = pat(i);
        bus.i_if_req  = 1'b0;
        bus.i_if_addr = '0;
        bus.i_d_req   = 1'b0;
        bus.i_d_we    = 1'b0;
        bus.i_d_be    = '0;
        bus.i_d_addr  = '0;
        bus.i_d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        // In reset with both requesting: no grants, RAM idle, no responses.
        step(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h40, '0, RSP_NONE, "rst_hold");
        fill  = 1'b0;
        rst_n = 1'b1;

        // First cycle after release: fetch 0x100 -> word 0x40.
        step(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0, RSP_IF, "fetch100");
        idle("fetch100_rsp");

        // Both requesting for six cycles: D,D,D,D,IF,D.
        for (int k = 0; k < 6; k++)
            step(1'b1, 32'h200 + 32'(4 * k), 1'b1, 1'b0, 4'hF, 32'h10 + 32'(4 * k), '0,
                 (k == 4) ? RSP_IF : RSP_D, "starve");
        idle("starve_rsp");

        // Partial-byte write then fetch of the same word, back to back.
        step(1'b0, '0, 1'b1, 1'b1, 4'b0010, 32'h8, 32'hAABBCCDD, RSP_D, "wr_be2");
        step(1'b1, 32'h8, 1'b0, 1'b0, '0, '0, '0, RSP_IF, "rd_be2");
        idle("rd_be2_rsp");

        // Zero byte-enable write is still granted and leaves the word unchanged.
        step(1'b0, '0, 1'b1, 1'b1, 4'b0000, 32'hC, 32'hFFFFFFFF, RSP_D, "wr_be0");
        step(1'b1, 32'hC, 1'b0, 1'b0, '0, '0, '0, RSP_IF, "rd_be0");

        // Full write then data read-back, back to back.
        step(1'b0, '0, 1'b1, 1'b1, 4'hF, 32'h3FC, 32'h12345678, RSP_D, "wr_full");
        step(1'b0, '0, 1'b1, 1'b0, 4'hF, 32'h3FC, '0, RSP_D, "rd_full");
        idle("rd_full_rsp");

        // Fetch dropped while data busy clears the starve counter.
        step(1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h20, '0, RSP_D, "drop_a");
        step(1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h24, '0, RSP_D, "drop_b");
        step(1'b0, 32'h80, 1'b1, 1'b0, 4'hF, 32'h28, '0, RSP_D, "drop_gone");
        for (int k = 0; k < 5; k++)
            step(1'b1, 32'h84, 1'b1, 1'b0, 4'hF, 32'h30 + 32'(4 * k), '0,
                 (k == 4) ? RSP_IF : RSP_D, "drop_after");
        idle("drop_rsp");

        // Reset the cycle after a data read grant, with the counter part-way up.
        step(1'b1, 32'h90, 1'b1, 1'b0, 4'hF, 32'h44, '0, RSP_D, "pre_rst_a");
        step(1'b1, 32'h90, 1'b1, 1'b0, 4'hF, 32'h48, '0, RSP_D, "pre_rst_b");
        rst_n = 1'b0;
        sbq.delete();
        step(1'b1, 32'h90, 1'b1, 1'b0, 4'hF, 32'h48, '0, RSP_NONE, "in_rst");
        rst_n = 1'b1;
        idle("post_rst");
        for (int k = 0; k < 5; k++)
            step(1'b1, 32'hA0, 1'b1, 1'b0, 4'hF, 32'h60 + 32'(4 * k), '0,
                 (k == 4) ? RSP_IF : RSP_D, "post_rst_cnt");
        idle("post_rst_rsp");
        idle("final_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data grants while fetch waits.
REQ-002 Parameter AW, default 32: address width.
REQ-003 i_clk  in  1  single clock, all state on rising edge.
REQ-004 i_reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_if_req  in  1  fetch request; i_if_addr  in  AW  fetch byte address.
REQ-006 o_if_gnt  out  1  fetch accepted this cycle; o_if_rvalid  out  1  fetch data valid; o_if_rdata  out  32.
REQ-007 i_d_req  in  1  data request; i_d_we  in  1  write; i_d_be  in  4  byte enables; i_d_addr  in  AW; i_d_wdata  in  32.
REQ-008 o_d_gnt  out  1  data accepted this cycle; o_d_rvalid  out  1  data completion; o_d_rdata  out  32.
REQ-009 o_mem_en, o_mem_we  out  1 each; o_mem_be  out  4; o_mem_addr  out  AW-2  word index (addr[AW-1:2]); o_mem_wdata  out  32.
REQ-010 i_mem_rdata  in  32  synchronous single-port RAM data, valid one cycle after o_mem_en.

Function
REQ-011 Grant decision combinational each cycle; at most one of o_if_gnt/o_d_gnt high.
REQ-012 Granted requester's address/we/be/wdata drive o_mem_* same cycle with o_mem_en=1; no grant -> o_mem_en=0, o_mem_we=0, o_mem_be=0.
REQ-013 Fetch grant forces o_mem_we=0, o_mem_be=4'hF.
REQ-014 Priority: data over fetch, except when starve counter == STARVE_LIMIT and i_if_req=1, then fetch wins.
REQ-015 Starve counter: +1 on data grant while i_if_req=1, clear on fetch grant or i_if_req=0, saturates at STARVE_LIMIT.
REQ-016 Response owner FSM states: RSP_NONE, RSP_IF, RSP_D; next state = RSP_IF on fetch grant, RSP_D on data grant, else RSP_NONE.
REQ-017 In RSP_IF: o_if_rvalid=1, o_if_rdata=i_mem_rdata; in RSP_D: o_d_rvalid=1, o_d_rdata=i_mem_rdata (writes: old word, ignored by requester).
REQ-018 Non-owner rvalid=0, rdata=0.
REQ-019 Back-to-back grants allowed every cycle; throughput one access/cycle, read latency exactly 1 cycle after gnt.
REQ-020 Requester holds req and payload until gnt; request dropped before gnt is legal and leaves no state.
REQ-021 Data request with i_d_be=0 still granted, o_mem_en=1, no bytes written, o_d_rvalid next cycle.
REQ-022 Simultaneous requests, counter < STARVE_LIMIT: data granted, fetch waits, no gnt.

Reset
REQ-023 Asynchronous on i_reset_n low: FSM=RSP_NONE, starve counter=0; all gnt/rvalid/o_mem_en/o_mem_we 0, rdata 0, o_mem_be 0.
REQ-024 While i_reset_n low no grants issued; response in flight at reset is dropped, no rvalid after release.
REQ-025 First grant possible in first cycle after i_reset_n deasserts.

Structure
REQ-026 Response-owner enum type and default STARVE_LIMIT in shared package alongside mem_ctrl_t.
REQ-027 Single module; starve counter and grant logic inline, no sub-module.
REQ-028 Counter width $clog2(STARVE_LIMIT+1).

Verification
REQ-029 Fetch only, addr 0x100 -> o_if_gnt same cycle, o_mem_addr=0x40, next cycle o_if_rvalid=1, rdata=mem[0x40].
REQ-030 Both req 6 cycles, STARVE_LIMIT=4 -> grants D,D,D,D,IF,D; rvalid owners follow one cycle later.
REQ-031 Data write be=4'b0010 addr 0x8 data 0xAABBCCDD, then fetch 0x8 -> o_mem_be=0010 on write; fetch rdata byte1=0xCC, others unchanged.
REQ-032 Reset asserted cycle after data read grant -> o_d_rvalid stays 0 after release, counter 0.
REQ-033 Fetch req dropped before gnt while data busy -> no o_if_gnt, no o_if_rvalid, counter cleared.
